// File: rtl/apple_spawn_ctrl_if.sv
// Occupancy query channel between the apple spawner and the snake-body store.
// Ports: occ_req/occ_x/occ_y driven by the spawner; occ_ack/occ_hit driven by the store.
// occ_hit is only meaningful in a cycle where occ_ack is high.
interface apple_spawn_ctrl_if;
    logic       occ_req;
    logic [6:0] occ_x;
    logic [5:0] occ_y;
    logic       occ_ack;
    logic       occ_hit;

    modport master (
        output occ_req,
        output occ_x,
        output occ_y,
        input  occ_ack,
        input  occ_hit
    );

    modport slave (
        input  occ_req,
        input  occ_x,
        input  occ_y,
        output occ_ack,
        output occ_hit
    );
endinterface

// File: rtl/apple_spawn_ctrl.sv
// Apple spawner: picks a free playfield cell (LFSR candidates, then linear scan) after each eat.
// Latency: apple_valid returns 4 cycles after an eaten pulse when the first query is acked at once.
// Backpressure: a query is held (occ_req high, coordinates stable) until occ_ack; no timeout.
// Ports: clk, reset (async, active-high), eaten, occ (query channel, master side),
//        apple_x/apple_y/apple_valid (current apple), score (saturating), board_full (sticky).
module apple_spawn_ctrl #(
    parameter int          GRID_W    = 64,
    parameter int          GRID_H    = 48,
    parameter int          MAX_TRIES = 15,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       eaten,
    apple_spawn_ctrl_if.master         occ,
    output logic [6:0]                 apple_x,
    output logic [5:0]                 apple_y,
    output logic                       apple_valid,
    output logic [3:0]                 score,
    output logic                       board_full
);

    localparam int          TW        = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [12:0] LAST_CELL = 13'(GRID_W * GRID_H - 1);
    localparam logic [6:0]  W_BOUND   = 7'(GRID_W);
    localparam logic [5:0]  H_BOUND   = 6'(GRID_H);
    localparam logic [6:0]  X_MAX     = 7'(GRID_W - 1);
    localparam logic [5:0]  Y_MAX     = 6'(GRID_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        QUERY,
        SCAN,
        COMMIT,
        FULL
    } state_t;

    state_t      state_q,     state_nxt;
    logic [15:0] lfsr_q,      lfsr_nxt;
    logic [6:0]  occ_x_q,     occ_x_nxt;
    logic [5:0]  occ_y_q,     occ_y_nxt;
    logic        occ_req_q,   occ_req_nxt;
    logic [6:0]  apple_x_q,   apple_x_nxt;
    logic [5:0]  apple_y_q,   apple_y_nxt;
    logic        apple_vld_q, apple_vld_nxt;
    logic [3:0]  score_q,     score_nxt;
    logic        full_q,      full_nxt;
    logic [TW-1:0] tries_q,   tries_nxt;
    logic [12:0] scan_cnt_q,  scan_cnt_nxt;

    // Random candidate folded into the grid with a single conditional subtract;
    // the legal parameter ranges guarantee one subtraction is always enough.
    logic [6:0] cand_x;
    logic [5:0] cand_y;
    logic [6:0] raw_x;
    logic [5:0] raw_y;

    always_comb begin
        raw_x  = lfsr_q[6:0];
        raw_y  = lfsr_q[13:8];
        cand_x = (raw_x >= W_BOUND) ? raw_x - W_BOUND : raw_x;
        cand_y = (raw_y >= H_BOUND) ? raw_y - H_BOUND : raw_y;
    end

    // Raster-order successor of the current query cell, wrapping at the end of the board.
    logic [6:0] step_x;
    logic [5:0] step_y;

    always_comb begin
        step_x = occ_x_q + 7'd1;
        step_y = occ_y_q;
        if (occ_x_q == X_MAX) begin
            step_x = 7'd0;
            step_y = (occ_y_q == Y_MAX) ? 6'd0 : occ_y_q + 6'd1;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        lfsr_nxt      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        occ_x_nxt     = occ_x_q;
        occ_y_nxt     = occ_y_q;
        occ_req_nxt   = occ_req_q;
        apple_x_nxt   = apple_x_q;
        apple_y_nxt   = apple_y_q;
        apple_vld_nxt = apple_vld_q;
        score_nxt     = score_q;
        full_nxt      = full_q;
        tries_nxt     = tries_q;
        scan_cnt_nxt  = scan_cnt_q;

        case (state_q)
            IDLE: begin
                if (eaten && apple_vld_q) begin
                    state_nxt     = GEN;
                    apple_vld_nxt = 1'b0;
                    score_nxt     = (score_q == 4'hF) ? score_q : score_q + 4'd1;
                    tries_nxt     = '0;
                end
            end

            GEN: begin
                occ_x_nxt   = cand_x;
                occ_y_nxt   = cand_y;
                tries_nxt   = tries_q + 1'b1;
                occ_req_nxt = 1'b1;
                state_nxt   = QUERY;
            end

            QUERY: begin
                if (occ.occ_ack) begin
                    occ_req_nxt = 1'b0;
                    if (!occ.occ_hit) begin
                        state_nxt = COMMIT;
                    end else if (tries_q < TW'(MAX_TRIES)) begin
                        state_nxt = GEN;
                    end else begin
                        // Scan starts from the cell after the last rejected candidate.
                        state_nxt    = SCAN;
                        scan_cnt_nxt = '0;
                    end
                end
            end

            SCAN: begin
                // occ_req low means the previous cell was just rejected (or the scan
                // just began): step the pointer and raise a fresh query.
                if (!occ_req_q) begin
                    occ_x_nxt   = step_x;
                    occ_y_nxt   = step_y;
                    occ_req_nxt = 1'b1;
                end else if (occ.occ_ack) begin
                    occ_req_nxt = 1'b0;
                    if (!occ.occ_hit) begin
                        state_nxt = COMMIT;
                    end else if (scan_cnt_q == LAST_CELL) begin
                        state_nxt = FULL;
                        full_nxt  = 1'b1;
                    end else begin
                        scan_cnt_nxt = scan_cnt_q + 13'd1;
                    end
                end
            end

            COMMIT: begin
                apple_x_nxt   = occ_x_q;
                apple_y_nxt   = occ_y_q;
                apple_vld_nxt = 1'b1;
                state_nxt     = IDLE;
            end

            FULL: begin
                full_nxt      = 1'b1;
                apple_vld_nxt = 1'b0;
                occ_req_nxt   = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            occ_x_q     <= 7'd0;
            occ_y_q     <= 6'd0;
            occ_req_q   <= 1'b0;
            apple_x_q   <= 7'd32;
            apple_y_q   <= 6'd24;
            apple_vld_q <= 1'b1;
            score_q     <= 4'd0;
            full_q      <= 1'b0;
            tries_q     <= '0;
            scan_cnt_q  <= 13'd0;
        end else begin
            state_q     <= state_nxt;
            lfsr_q      <= lfsr_nxt;
            occ_x_q     <= occ_x_nxt;
            occ_y_q     <= occ_y_nxt;
            occ_req_q   <= occ_req_nxt;
            apple_x_q   <= apple_x_nxt;
            apple_y_q   <= apple_y_nxt;
            apple_vld_q <= apple_vld_nxt;
            score_q     <= score_nxt;
            full_q      <= full_nxt;
            tries_q     <= tries_nxt;
            scan_cnt_q  <= scan_cnt_nxt;
        end
    end

    assign occ.occ_req  = occ_req_q;
    assign occ.occ_x    = occ_x_q;
    assign occ.occ_y    = occ_y_q;
    assign apple_x      = apple_x_q;
    assign apple_y      = apple_y_q;
    assign apple_valid  = apple_vld_q;
    assign score        = score_q;
    assign board_full   = full_q;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Bench for apple_spawn_ctrl: directed sequence with randomized ack delays and hit counts,
// checked against a reference built from the LFSR rule, in-grid folding and raster-index scanning.
module tb_apple_spawn_ctrl;

    localparam int          GW   = 64;
    localparam int          GH   = 48;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       eaten;
    logic [6:0] apple_x;
    logic [5:0] apple_y;
    logic       apple_valid;
    logic [3:0] score;
    logic       board_full;

    apple_spawn_ctrl_if occ ();

    apple_spawn_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .eaten       (eaten),
        .occ         (occ),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .score       (score),
        .board_full  (board_full)
    );

    always #5 clk = ~clk;

    int passed       = 0;
    int total        = 0;
    int nq           = 0;
    int unstable     = 0;
    int req_timeouts = 0;

    // Reference LFSR: m is the value during the current cycle, mp the value one cycle earlier.
    logic [15:0] m  = SEED;
    logic [15:0] mp = SEED;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m  = SEED;
            mp = SEED;
        end else begin
            mp = m;
            m  = lfsr_step(m);
        end
    end

    function automatic logic [12:0] cand(input logic [15:0] v);
        int x;
        int y;
        x = int'(v[6:0]);
        y = int'(v[13:8]);
        if (x >= GW) x = x - GW;
        if (y >= GH) y = y - GH;
        return {7'(x), 6'(y)};
    endfunction

    function automatic logic [12:0] next_cell(input logic [12:0] c);
        int idx;
        idx = int'(c[12:6]) + int'(c[5:0]) * GW;
        idx = (idx + 1) % (GW * GH);
        return {7'(idx % GW), 6'(idx / GW)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (occ.occ_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) req_timeouts++;
    endtask

    // Answer the pending query after 'delay' idle cycles, watching that the request stays put.
    task automatic answer(input bit hit, input int delay);
        logic [6:0] x0;
        logic [5:0] y0;
        x0 = occ.occ_x;
        y0 = occ.occ_y;
        for (int d = 0; d < delay; d++) begin
            tick();
            if (occ.occ_req !== 1'b1 || occ.occ_x !== x0 || occ.occ_y !== y0) unstable++;
        end
        occ.occ_ack = 1'b1;
        occ.occ_hit = hit;
        tick();
        occ.occ_ack = 1'b0;
        occ.occ_hit = 1'b0;
        nq++;
        if (occ.occ_req !== 1'b0) unstable++;
    endtask

    task automatic pulse_eaten();
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        bit          found;
        int          badc;
        int          oob;
        int          nh;
        int          exp_score;
        logic [12:0] c;
        logic [12:0] s1;
        logic [12:0] s2;

        reset       = 1'b1;
        eaten       = 1'b0;
        occ.occ_ack = 1'b0;
        occ.occ_hit = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset.
        repeat (10) tick();
        check("rst_apple_x", 32'(apple_x), 32);
        check("rst_apple_y", 32'(apple_y), 24);
        check("rst_valid", 32'(apple_valid), 1);
        check("rst_score", 32'(score), 0);
        check("rst_occ_req", 32'(occ.occ_req), 0);
        check("rst_full", 32'(board_full), 0);

        // Minimum latency: immediate miss on the first candidate.
        pulse_eaten();
        check("lat_valid_gen", 32'(apple_valid), 0);
        check("lat_score", 32'(score), 1);
        tick();
        check("lat_req", 32'(occ.occ_req), 1);
        c = cand(mp);
        check("lat_occ_x", 32'(occ.occ_x), 32'(c[12:6]));
        check("lat_occ_y", 32'(occ.occ_y), 32'(c[5:0]));
        occ.occ_ack = 1'b1;
        occ.occ_hit = 1'b0;
        tick();
        occ.occ_ack = 1'b0;
        check("lat_valid_commit", 32'(apple_valid), 0);
        check("lat_req_drop", 32'(occ.occ_req), 0);
        tick();
        check("lat_valid_4", 32'(apple_valid), 1);
        check("lat_apple_x", 32'(apple_x), 32'(c[12:6]));
        check("lat_apple_y", 32'(apple_y), 32'(c[5:0]));

        // 15 random hits, then scan: hit on cell 1, miss on cell 2 (wrapped to column 0).
        nq   = 0;
        badc = 0;
        pulse_eaten();
        for (int q = 0; q < 14; q++) begin
            wait_req(ok);
            c = cand(mp);
            if (occ.occ_x !== c[12:6] || occ.occ_y !== c[5:0]) badc++;
            if (q < 13) begin
                answer(1'b1, $urandom_range(0, 2));
            end else begin
                // Time the ack so the final random candidate lands on column GW-2.
                found = 1'b0;
                for (int w = 0; w < 3000; w++) begin
                    c = cand(lfsr_step(m));
                    if (int'(c[12:6]) == GW - 2) begin
                        found = 1'b1;
                        break;
                    end
                    tick();
                end
                check("wrap_align", 32'(found), 1);
                answer(1'b1, 0);
            end
        end
        wait_req(ok);
        c = cand(mp);
        check("cand15_x", 32'(occ.occ_x), 32'(GW - 2));
        check("cand15_y", 32'(occ.occ_y), 32'(c[5:0]));
        answer(1'b1, $urandom_range(0, 2));
        s1 = next_cell(c);
        wait_req(ok);
        check("scan1_x", 32'(occ.occ_x), 32'(s1[12:6]));
        check("scan1_y", 32'(occ.occ_y), 32'(s1[5:0]));
        answer(1'b1, 0);
        s2 = next_cell(s1);
        wait_req(ok);
        check("scan2_x", 32'(occ.occ_x), 0);
        check("scan2_y", 32'(occ.occ_y), 32'(s2[5:0]));
        answer(1'b0, 1);
        tick();
        check("scan_queries", 32'(nq), 17);
        check("scan_badc", 32'(badc), 0);
        check("scan_valid", 32'(apple_valid), 1);
        check("scan_apple_x", 32'(apple_x), 32'(s2[12:6]));
        check("scan_apple_y", 32'(apple_y), 32'(s2[5:0]));
        check("scan_score", 32'(score), 2);

        // Score saturation with random hit counts and ack delays; extra eaten while invalid.
        exp_score = 2;
        for (int i = 0; i < 14; i++) begin
            eaten = 1'b1;
            tick();
            if (i == 0) tick();
            eaten = 1'b0;
            exp_score = (exp_score + 1 > 15) ? 15 : exp_score + 1;
            nh   = $urandom_range(0, 3);
            badc = 0;
            for (int h = 0; h <= nh; h++) begin
                wait_req(ok);
                c = cand(mp);
                if (occ.occ_x !== c[12:6] || occ.occ_y !== c[5:0]) badc++;
                answer(h < nh, $urandom_range(0, 3));
            end
            tick();
            check("sat_badc", 32'(badc), 0);
            check("sat_valid", 32'(apple_valid), 1);
            check("sat_apple_x", 32'(apple_x), 32'(c[12:6]));
            check("sat_apple_y", 32'(apple_y), 32'(c[5:0]));
            check("sat_score", 32'(score), 32'(exp_score));
        end

        // Reset while a query is outstanding.
        pulse_eaten();
        wait_req(ok);
        repeat (3) tick();
        check("mid_req_pending", 32'(occ.occ_req), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(occ.occ_req), 0);
        check("mid_rst_x", 32'(occ.occ_x), 0);
        check("mid_rst_y", 32'(occ.occ_y), 0);
        check("mid_rst_apple_x", 32'(apple_x), 32);
        check("mid_rst_apple_y", 32'(apple_y), 24);
        check("mid_rst_valid", 32'(apple_valid), 1);
        check("mid_rst_score", 32'(score), 0);
        check("mid_rst_full", 32'(board_full), 0);
        tick();
        check("mid_rst_req_hold", 32'(occ.occ_req), 0);
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_req", 32'(occ.occ_req), 0);

        // Every cell occupied: 15 random + GW*GH scan queries, then FULL.
        nq   = 0;
        badc = 0;
        oob  = 0;
        pulse_eaten();
        for (int q = 0; q < 15; q++) begin
            wait_req(ok);
            c = cand(mp);
            if (occ.occ_x !== c[12:6] || occ.occ_y !== c[5:0]) badc++;
            if (int'(occ.occ_x) >= GW || int'(occ.occ_y) >= GH) oob++;
            answer(1'b1, $urandom_range(0, 2));
        end
        for (int s = 0; s < GW * GH; s++) begin
            c = next_cell(c);
            wait_req(ok);
            if (!ok) break;
            if (occ.occ_x !== c[12:6] || occ.occ_y !== c[5:0]) badc++;
            if (int'(occ.occ_x) >= GW || int'(occ.occ_y) >= GH) oob++;
            answer(1'b1, 0);
        end
        check("full_queries", 32'(nq), 32'(15 + GW * GH));
        check("full_badc", 32'(badc), 0);
        check("full_oob", 32'(oob), 0);
        check("full_flag", 32'(board_full), 1);
        check("full_valid", 32'(apple_valid), 0);
        repeat (4) tick();
        check("full_req_idle", 32'(occ.occ_req), 0);
        pulse_eaten();
        repeat (3) tick();
        check("full_eaten_score", 32'(score), 1);
        check("full_eaten_req", 32'(occ.occ_req), 0);
        check("full_sticky", 32'(board_full), 1);
        check("full_valid_hold", 32'(apple_valid), 0);

        check("handshake_unstable", 32'(unstable), 0);
        check("req_timeouts", 32'(req_timeouts), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apple_spawn_ctrl.md
APPLE_SPAWN_CTRL -- requirements
Module: apple_spawn_ctrl

Interface
REQ-001 The block SHALL have parameter GRID_W, default 64, playfield width in cells (legal range 64..127).
REQ-002 The block SHALL have parameter GRID_H, default 48, playfield height in cells (legal range 32..63).
REQ-003 The block SHALL have parameter MAX_TRIES, default 15, random candidates tried before linear-scan fallback.
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-005 The block SHALL have ports in this order: clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 The block SHALL have port eaten, input, 1, single-cycle pulse: snake head is on the apple.
REQ-008 The block SHALL have port occ_req, output, 1, occupancy query valid.
REQ-009 The block SHALL have ports occ_x and occ_y, outputs, 7 and 6 bits, queried cell.
REQ-010 The block SHALL have port occ_ack, input, 1, query answered this cycle.
REQ-011 The block SHALL have port occ_hit, input, 1, queried cell holds snake body; valid only with occ_ack.
REQ-012 The block SHALL have port apple_x, output, 7 bits, apple column.
REQ-013 The block SHALL have port apple_y, output, 6 bits, apple row.
REQ-014 The block SHALL have port apple_valid, output, 1, apple placed and edible.
REQ-015 The block SHALL have port score, output, 4 bits, apples eaten, saturating at 15.
REQ-016 The block SHALL have port board_full, output, 1, no free cell found; sticky until reset.

Function
REQ-017 The LFSR SHALL be 16-bit Fibonacci, shift left, new bit0 = b15^b13^b12^b10, advancing every cycle outside reset.
REQ-018 The random candidate SHALL be cx = lfsr[6:0] and cy = lfsr[13:8], each reduced by one subtraction of GRID_W or GRID_H when >= that bound.
REQ-019 The FSM SHALL have states IDLE, GEN, QUERY, SCAN, COMMIT, FULL.
REQ-020 IDLE: on eaten=1 with apple_valid=1, the FSM SHALL go to GEN, clear apple_valid, increment score (hold at 15) and clear the try counter.
REQ-021 eaten SHALL be ignored in every state other than IDLE and whenever apple_valid=0.
REQ-022 GEN: the FSM SHALL latch the random candidate into occ_x/occ_y, increment the try counter and go to QUERY; this takes one cycle.
REQ-023 QUERY: occ_req SHALL be 1 and occ_x/occ_y held stable until the cycle occ_ack=1; occ_req SHALL drop the cycle after ack.
REQ-024 On ack with occ_hit=0 the FSM SHALL go to COMMIT.
REQ-025 On ack with occ_hit=1 the FSM SHALL go to GEN if tries < MAX_TRIES; otherwise it SHALL go to SCAN with the scan pointer at the last candidate.
REQ-026 SCAN: the scan pointer SHALL advance x+1, wrapping GRID_W-1 to 0 with y+1, and y wrapping GRID_H-1 to 0; each step SHALL issue a query with the same handshake as QUERY.
REQ-027 In SCAN, a miss SHALL go to COMMIT; if GRID_W*GRID_H consecutive scan cells hit, the FSM SHALL go to FULL.
REQ-028 COMMIT: apple_x/apple_y SHALL load occ_x/occ_y, apple_valid SHALL be 1 from the next cycle, and the FSM SHALL return to IDLE.
REQ-029 FULL: board_full SHALL be 1, apple_valid SHALL be 0, and the FSM SHALL stay in FULL until reset.
REQ-030 Minimum latency from eaten to apple_valid=1 SHALL be 4 cycles when occ_ack returns in the first QUERY cycle.
REQ-031 occ_x/occ_y SHALL always be inside the grid.

Reset
REQ-032 On reset=1, the block SHALL asynchronously set state=IDLE, apple_x=32, apple_y=24, apple_valid=1, score=0, board_full=0, occ_req=0, occ_x=0, occ_y=0, try counter=0 and lfsr=LFSR_SEED.
REQ-033 Reset asserted mid-QUERY or mid-SCAN SHALL abort the search, and occ_req SHALL be 0 while reset is high.

Verification
REQ-034 Release reset, idle 10 cycles -> apple=(32,24), apple_valid=1, score=0, occ_req=0.
REQ-035 Pulse eaten, occupancy model acks the same cycle with hit=0 -> apple_valid returns after 4 cycles at the in-grid LFSR-predicted cell, score=1.
REQ-036 Model hits all 15 random candidates, then misses at scan cell 2 -> exactly 17 queries, apple at the second scan cell, wrap from x=63 to x=0 with y+1 exercised.
REQ-037 Model answers hit=1 for every cell (64x48 grid) -> board_full=1 and apple_valid=0 after 15+3072 queries; eaten pulses are ignored afterwards.
REQ-038 16 eaten pulses with free cells -> score=15 and stays at 15; an eaten pulse while apple_valid=0 -> no score change.
REQ-039 Assert reset while occ_req=1 with occ_ack held low -> occ_req drops immediately and all REQ-032 values are present.
